// File: rtl/alu_result_checker_if.sv
// Transaction bus between the ALU under test and its result checker:
// operands, control and the ALU's own result/zero flag, qualified by in_valid.
interface alu_result_checker_if;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  aluc;
   logic [31:0] r;
   logic        z;

   modport master (output in_valid, a, b, aluc, r, z);
   modport slave  (input  in_valid, a, b, aluc, r, z);
endinterface

// File: rtl/alu_result_checker.sv
// Two-stage scoreboard for the 32-bit ALU: recomputes the golden result,
// compares it with the ALU output and keeps saturating counters plus a first-fail capture.
module alu_result_checker #(
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   alu_result_checker_if.slave   bus,
   output logic [CNT_W-1:0]      pass_cnt,
   output logic [CNT_W-1:0]      fail_cnt,
   output logic                  mismatch,
   output logic                  any_fail,
   output logic                  cap_valid,
   output logic [3:0]            cap_aluc,
   output logic [31:0]           cap_a,
   output logic [31:0]           cap_b,
   output logic [31:0]           cap_r,
   output logic [31:0]           cap_exp,
   output logic                  busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [31:0] exp_res;

   logic        s1_valid;
   logic [3:0]  s1_aluc;
   logic [31:0] s1_a;
   logic [31:0] s1_b;
   logic [31:0] s1_r;
   logic        s1_z;
   logic [31:0] s1_exp;
   logic        s1_expz;

   logic        s2_valid;
   logic        s2_fail;
   logic [3:0]  s2_aluc;
   logic [31:0] s2_a;
   logic [31:0] s2_b;
   logic [31:0] s2_r;
   logic [31:0] s2_exp;

   // aluc[1:0] picks the operation family, aluc[2] the variant; aluc[3] only splits SRL/SRA
   always_comb begin
      exp_res = '0;
      case (bus.aluc[1:0])
         2'b00:   exp_res = bus.aluc[2] ? (bus.a - bus.b) : (bus.a + bus.b);
         2'b01:   exp_res = bus.aluc[2] ? (bus.a | bus.b) : (bus.a & bus.b);
         2'b10:   exp_res = bus.aluc[2] ? {bus.b[15:0], 16'h0000} : (bus.a ^ bus.b);
         default: begin
            if (!bus.aluc[2])
               exp_res = bus.b << bus.a[4:0];
            else if (bus.aluc[3])
               exp_res = 32'($signed(bus.b) >>> bus.a[4:0]);
            else
               exp_res = bus.b >> bus.a[4:0];
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_aluc   <= '0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_r      <= '0;
         s1_z      <= 1'b0;
         s1_exp    <= '0;
         s1_expz   <= 1'b0;
         s2_valid  <= 1'b0;
         s2_fail   <= 1'b0;
         s2_aluc   <= '0;
         s2_a      <= '0;
         s2_b      <= '0;
         s2_r      <= '0;
         s2_exp    <= '0;
         pass_cnt  <= '0;
         fail_cnt  <= '0;
         mismatch  <= 1'b0;
         any_fail  <= 1'b0;
         cap_valid <= 1'b0;
         cap_aluc  <= '0;
         cap_a     <= '0;
         cap_b     <= '0;
         cap_r     <= '0;
         cap_exp   <= '0;
      end else begin
         s1_valid <= bus.in_valid;
         s1_aluc  <= bus.aluc;
         s1_a     <= bus.a;
         s1_b     <= bus.b;
         s1_r     <= bus.r;
         s1_z     <= bus.z;
         s1_exp   <= exp_res;
         s1_expz  <= (exp_res == 32'h0);

         s2_valid <= s1_valid;
         s2_fail  <= (s1_r != s1_exp) || (s1_z != s1_expz);
         s2_aluc  <= s1_aluc;
         s2_a     <= s1_a;
         s2_b     <= s1_b;
         s2_r     <= s1_r;
         s2_exp   <= s1_exp;

         mismatch <= 1'b0;
         // clear discards a result landing on the same edge but leaves the pipeline running
         if (clear) begin
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            any_fail  <= 1'b0;
            cap_valid <= 1'b0;
            cap_aluc  <= '0;
            cap_a     <= '0;
            cap_b     <= '0;
            cap_r     <= '0;
            cap_exp   <= '0;
         end else if (s2_valid) begin
            if (s2_fail) begin
               if (fail_cnt != CNT_MAX)
                  fail_cnt <= fail_cnt + CNT_W'(1);
               mismatch <= 1'b1;
               any_fail <= 1'b1;
               if (!cap_valid) begin
                  cap_valid <= 1'b1;
                  cap_aluc  <= s2_aluc;
                  cap_a     <= s2_a;
                  cap_b     <= s2_b;
                  cap_r     <= s2_r;
                  cap_exp   <= s2_exp;
               end
            end else if (pass_cnt != CNT_MAX) begin
               pass_cnt <= pass_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign busy = s1_valid | s2_valid;

endmodule
